// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data memory arbiter: FSM states, priority encoding and
// default geometry.
package data_mem_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        VEC  = 1'b1
    } state_e;

    typedef enum logic {
        PRIO_S = 1'b0,
        PRIO_V = 1'b1
    } prio_e;

    localparam int N_DEFAULT     = 24;
    localparam int LANES_DEFAULT = 4;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of scalar requester, vector requester and memory signals, plus debug
// visibility of the arbiter FSM state and priority register.
interface data_mem_arbiter_if
    import data_mem_arbiter_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int LANES = LANES_DEFAULT
);

    // Scalar requester
    logic               ReqS;
    logic               WeS;
    logic [N-1:0]       AddrS;
    logic [N-1:0]       WDataS;
    logic [N-1:0]       RDataS;
    logic               GntS;
    logic               StallS;

    // Vector requester: ReqV is held until the DoneV pulse, then may drop
    logic               ReqV;
    logic               WeV;
    logic [N-1:0]       AddrV;
    logic [LANES*N-1:0] WDataV;
    logic [LANES*N-1:0] RDataV;
    logic               DoneV;
    logic               BusyV;

    // Memory port; MemRData is combinational from MemAddr
    logic [N-1:0]       MemAddr;
    logic [N-1:0]       MemWData;
    logic               MemWE;
    logic [N-1:0]       MemRData;

    state_e             dbg_state;
    prio_e              dbg_prio;

    modport arb (
        input  ReqS, WeS, AddrS, WDataS,
        input  ReqV, WeV, AddrV, WDataV,
        input  MemRData,
        output RDataS, GntS, StallS,
        output RDataV, DoneV, BusyV,
        output MemAddr, MemWData, MemWE,
        output dbg_state, dbg_prio
    );

    modport requester (
        output ReqS, WeS, AddrS, WDataS,
        output ReqV, WeV, AddrV, WDataV,
        input  RDataS, GntS, StallS,
        input  RDataV, DoneV, BusyV
    );

    modport memory (
        input  MemAddr, MemWData, MemWE,
        output MemRData
    );

endinterface

// File: rtl/data_mem_arbiter_arb_rr2.sv
// Two-requester round-robin decision (scalar vs vector) with the priority
// register that remembers which side goes first on the next contention.
module arb_rr2
    import data_mem_arbiter_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  en_i,
    input  logic  req_s_i,
    input  logic  req_v_i,
    output logic  gnt_s_o,
    output logic  gnt_v_o,
    output prio_e prio_o
);

    prio_e prio_q, prio_d;
    logic  gnt_s, gnt_v;

    always_comb begin
        gnt_s  = en_i & req_s_i & ~(req_v_i & (prio_q == PRIO_V));
        gnt_v  = en_i & req_v_i & (~req_s_i | (prio_q == PRIO_V));
        prio_d = prio_q;
        // A losing vector request earns priority; a winning one hands it back
        if (gnt_v) begin
            prio_d = PRIO_S;
        end else if (gnt_s && req_v_i) begin
            prio_d = PRIO_V;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= PRIO_S;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign gnt_s_o = gnt_s;
    assign gnt_v_o = gnt_v;
    assign prio_o  = prio_q;

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates one memory port between a single-cycle scalar requester and a
// multi-beat vector requester (LANES consecutive words per access).
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int LANES = LANES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    data_mem_arbiter_if.arb     bus_io
);

    localparam int            BW        = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(LANES - 1);

    state_e             state_q, state_d;
    logic [BW-1:0]      beat_q, beat_d;
    logic [N-1:0]       base_q, base_d;
    logic               we_q, we_d;
    logic [LANES*N-1:0] wdata_q, wdata_d;
    logic [LANES*N-1:0] rdata_q, rdata_d;
    logic               done_q, done_d;

    logic               idle_en;
    logic               req_v_eff;
    logic               gnt_s, gnt_v;
    prio_e              prio;
    logic [N-1:0]       lane_wdata;

    // ReqV is still high in the DoneV cycle and must not restart a transfer
    assign idle_en   = (state_q == IDLE) && !rst;
    assign req_v_eff = bus_io.ReqV && !done_q;

    arb_rr2 u_arb (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (idle_en),
        .req_s_i (bus_io.ReqS),
        .req_v_i (req_v_eff),
        .gnt_s_o (gnt_s),
        .gnt_v_o (gnt_v),
        .prio_o  (prio)
    );

    always_comb begin
        lane_wdata = '0;
        for (int i = 0; i < LANES; i++) begin
            if (beat_q == BW'(i)) begin
                lane_wdata = wdata_q[i*N +: N];
            end
        end
    end

    always_comb begin
        bus_io.GntS     = gnt_s;
        bus_io.StallS   = bus_io.ReqS & ~gnt_s & ~rst;
        bus_io.BusyV    = (state_q == VEC) & ~rst;
        bus_io.DoneV    = done_q;
        bus_io.RDataV   = rdata_q;
        bus_io.RDataS   = '0;
        bus_io.MemAddr  = '0;
        bus_io.MemWData = '0;
        bus_io.MemWE    = 1'b0;
        bus_io.dbg_state = state_q;
        bus_io.dbg_prio  = prio;
        if (gnt_s) begin
            bus_io.MemAddr  = bus_io.AddrS;
            bus_io.MemWData = bus_io.WDataS;
            bus_io.MemWE    = bus_io.WeS;
            bus_io.RDataS   = bus_io.MemRData;
        end else if ((state_q == VEC) && !rst) begin
            bus_io.MemAddr  = base_q + N'(beat_q);
            bus_io.MemWData = lane_wdata;
            bus_io.MemWE    = we_q;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        base_d  = base_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_v) begin
                    state_d = VEC;
                    beat_d  = '0;
                    base_d  = bus_io.AddrV;
                    we_d    = bus_io.WeV;
                    wdata_d = bus_io.WDataV;
                end
            end
            VEC: begin
                beat_d = beat_q + 1'b1;
                if (!we_q) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (beat_q == BW'(i)) begin
                            rdata_d[i*N +: N] = bus_io.MemRData;
                        end
                    end
                end
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            base_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus a randomized run checked
// against a cycle-level reference model of the arbitration rules.
module tb_data_mem_arbiter;
    import data_mem_arbiter_pkg::*;

    localparam int N     = 24;
    localparam int LANES = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    data_mem_arbiter_if #(.N(N), .LANES(LANES)) bus();

    data_mem_arbiter #(.N(N), .LANES(LANES)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    // Memory environment: 256 words, low address byte selects the word
    logic [N-1:0] mem [256];
    assign bus.MemRData = mem[bus.MemAddr[7:0]];
    always @(posedge clk) if (bus.MemWE) mem[bus.MemAddr[7:0]] <= bus.MemWData;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2*N-1:0]     exp_q[$];
    logic [LANES*N-1:0] exp_rdatav = '0;

    task automatic idle_inputs();
        bus.ReqS = 1'b0; bus.WeS = 1'b0; bus.AddrS = '0; bus.WDataS = '0;
        bus.ReqV = 1'b0; bus.WeV = 1'b0; bus.AddrV = '0; bus.WDataV = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_rdatav = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.ReqS = 1'b1; bus.WeS = 1'b1; bus.AddrS = 24'h10;
        bus.ReqV = 1'b1; bus.WeV = 1'b1;
        #1;
        n_checks++; if (bus.GntS !== 1'b0) begin n_fail++; $display("FAIL rst_gnts: got %0h want 0", bus.GntS); end
        n_checks++; if (bus.StallS !== 1'b0) begin n_fail++; $display("FAIL rst_stalls: got %0h want 0", bus.StallS); end
        n_checks++; if (bus.MemWE !== 1'b0) begin n_fail++; $display("FAIL rst_memwe: got %0h want 0", bus.MemWE); end
        n_checks++; if (bus.BusyV !== 1'b0) begin n_fail++; $display("FAIL rst_busyv: got %0h want 0", bus.BusyV); end
        n_checks++; if (bus.RDataS !== '0) begin n_fail++; $display("FAIL rst_rdatas: got %0h want 0", bus.RDataS); end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        exp_rdatav = '0;
        #1;
        n_checks++; if (bus.DoneV !== 1'b0) begin n_fail++; $display("FAIL post_rst_donev: got %0h want 0", bus.DoneV); end
        n_checks++; if (bus.RDataV !== '0) begin n_fail++; $display("FAIL post_rst_rdatav: got %0h want 0", bus.RDataV); end
        n_checks++; if (bus.MemAddr !== '0 || bus.MemWData !== '0) begin n_fail++; $display("FAIL post_rst_membus: got %0h/%0h want 0/0", bus.MemAddr, bus.MemWData); end
        n_checks++; if (bus.dbg_state !== IDLE) begin n_fail++; $display("FAIL post_rst_state: got %0h want IDLE", bus.dbg_state); end
    endtask

    task automatic test_scalar();
        logic [N-1:0] wd;
        wd = N'($urandom);
        @(negedge clk);
        bus.ReqS = 1'b1; bus.WeS = 1'b0; bus.AddrS = 24'h10;
        #1;
        n_checks++; if (bus.GntS !== 1'b1) begin n_fail++; $display("FAIL scalar_gnt: got %0h want 1", bus.GntS); end
        n_checks++; if (bus.RDataS !== 24'hABCDEF) begin n_fail++; $display("FAIL scalar_rdata: got %0h want abcdef", bus.RDataS); end
        n_checks++; if (bus.StallS !== 1'b0) begin n_fail++; $display("FAIL scalar_stall: got %0h want 0", bus.StallS); end
        n_checks++; if (bus.MemWE !== 1'b0) begin n_fail++; $display("FAIL scalar_we: got %0h want 0", bus.MemWE); end
        n_checks++; if (bus.MemAddr !== 24'h10) begin n_fail++; $display("FAIL scalar_addr: got %0h want 10", bus.MemAddr); end
        @(negedge clk);
        bus.WeS = 1'b1; bus.AddrS = 24'h33; bus.WDataS = wd;
        #1;
        n_checks++; if (bus.MemWE !== 1'b1 || bus.MemAddr !== 24'h33 || bus.MemWData !== wd) begin n_fail++; $display("FAIL scalar_write: got we=%0h a=%0h d=%0h want 1/33/%0h", bus.MemWE, bus.MemAddr, bus.MemWData, wd); end
        @(negedge clk);
        bus.WeS = 1'b0;
        #1;
        n_checks++; if (bus.RDataS !== wd) begin n_fail++; $display("FAIL scalar_readback: got %0h want %0h", bus.RDataS, wd); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic vec_xfer(input string tag, input logic we, input logic [N-1:0] addr,
                            input logic [LANES*N-1:0] wdata);
        logic [N-1:0] ea;
        @(negedge clk);
        bus.ReqV = 1'b1; bus.WeV = we; bus.AddrV = addr; bus.WDataV = wdata;
        #1;
        n_checks++; if (bus.MemWE !== 1'b0 || bus.BusyV !== 1'b0) begin n_fail++; $display("FAIL %s_accept: got we=%0h busy=%0h want 0/0", tag, bus.MemWE, bus.BusyV); end
        for (int i = 0; i < LANES; i++) begin
            @(negedge clk);
            #1;
            ea = addr + N'(i);
            n_checks++; if (bus.BusyV !== 1'b1 || bus.DoneV !== 1'b0) begin n_fail++; $display("FAIL %s_beat%0d_flags: got busy=%0h done=%0h want 1/0", tag, i, bus.BusyV, bus.DoneV); end
            n_checks++; if (bus.MemAddr !== ea || bus.MemWE !== we) begin n_fail++; $display("FAIL %s_beat%0d_addr: got a=%0h we=%0h want %0h/%0h", tag, i, bus.MemAddr, bus.MemWE, ea, we); end
            if (we) begin
                n_checks++; if (bus.MemWData !== wdata[i*N +: N]) begin n_fail++; $display("FAIL %s_beat%0d_wdata: got %0h want %0h", tag, i, bus.MemWData, wdata[i*N +: N]); end
            end else begin
                exp_rdatav[i*N +: N] = mem[ea[7:0]];
            end
        end
        @(negedge clk);
        #1;
        n_checks++; if (bus.DoneV !== 1'b1 || bus.BusyV !== 1'b0 || bus.MemWE !== 1'b0) begin n_fail++; $display("FAIL %s_done: got done=%0h busy=%0h we=%0h want 1/0/0", tag, bus.DoneV, bus.BusyV, bus.MemWE); end
        n_checks++; if (bus.RDataV !== exp_rdatav) begin n_fail++; $display("FAIL %s_rdatav: got %0h want %0h", tag, bus.RDataV, exp_rdatav); end
        @(negedge clk);
        bus.ReqV = 1'b0;
        #1;
        n_checks++; if (bus.DoneV !== 1'b0 || bus.BusyV !== 1'b0) begin n_fail++; $display("FAIL %s_after: got done=%0h busy=%0h want 0/0", tag, bus.DoneV, bus.BusyV); end
    endtask

    task automatic test_vec_write();
        logic [LANES*N-1:0] wd;
        for (int k = 0; k < LANES; k++) wd[k*N +: N] = N'($urandom);
        vec_xfer("vwrite", 1'b1, 24'h20, wd);
    endtask

    task automatic test_wrap();
        vec_xfer("vwrap", 1'b0, 24'hFFFFFE, '0);
    endtask

    task automatic test_contention();
        logic [N-1:0] ea;
        do_reset();
        @(negedge clk);
        bus.ReqS = 1'b1; bus.WeS = 1'b0; bus.AddrS = 24'h10;
        bus.ReqV = 1'b1; bus.WeV = 1'b0; bus.AddrV = 24'h80;
        #1;
        n_checks++; if (bus.GntS !== 1'b1 || bus.RDataS !== mem[8'h10]) begin n_fail++; $display("FAIL cont_first: got gnt=%0h rd=%0h want 1/%0h", bus.GntS, bus.RDataS, mem[8'h10]); end
        @(negedge clk);
        #1;
        n_checks++; if (bus.GntS !== 1'b0 || bus.StallS !== 1'b1 || bus.MemWE !== 1'b0) begin n_fail++; $display("FAIL cont_accept: got gnt=%0h stall=%0h we=%0h want 0/1/0", bus.GntS, bus.StallS, bus.MemWE); end
        for (int i = 0; i < LANES; i++) begin
            @(negedge clk);
            #1;
            ea = 24'h80 + N'(i);
            n_checks++; if (bus.StallS !== 1'b1 || bus.GntS !== 1'b0 || bus.BusyV !== 1'b1 || bus.MemAddr !== ea) begin n_fail++; $display("FAIL cont_beat%0d: got stall=%0h gnt=%0h busy=%0h a=%0h want 1/0/1/%0h", i, bus.StallS, bus.GntS, bus.BusyV, bus.MemAddr, ea); end
            exp_rdatav[i*N +: N] = mem[ea[7:0]];
        end
        @(negedge clk);
        #1;
        n_checks++; if (bus.DoneV !== 1'b1 || bus.GntS !== 1'b1 || bus.StallS !== 1'b0 || bus.MemAddr !== 24'h10) begin n_fail++; $display("FAIL cont_done: got done=%0h gnt=%0h stall=%0h a=%0h want 1/1/0/10", bus.DoneV, bus.GntS, bus.StallS, bus.MemAddr); end
        n_checks++; if (bus.RDataV !== exp_rdatav) begin n_fail++; $display("FAIL cont_rdatav: got %0h want %0h", bus.RDataV, exp_rdatav); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (bus.DoneV !== 1'b0 || bus.BusyV !== 1'b0) begin n_fail++; $display("FAIL cont_after: got done=%0h busy=%0h want 0/0", bus.DoneV, bus.BusyV); end
    endtask

    task automatic test_reset_mid_vec();
        @(negedge clk);
        bus.ReqV = 1'b1; bus.WeV = 1'b1; bus.AddrV = 24'h40; bus.WDataV = {LANES{24'h5A5A5A}};
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        #1;
        n_checks++; if (bus.MemWE !== 1'b0 || bus.BusyV !== 1'b0 || bus.GntS !== 1'b0) begin n_fail++; $display("FAIL midrst_during: got we=%0h busy=%0h gnt=%0h want 0/0/0", bus.MemWE, bus.BusyV, bus.GntS); end
        @(negedge clk);
        rst = 1'b0;
        exp_rdatav = '0;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++; if (bus.MemWE !== 1'b0 || bus.DoneV !== 1'b0 || bus.BusyV !== 1'b0 || bus.RDataV !== '0) begin n_fail++; $display("FAIL midrst_after%0d: got we=%0h done=%0h busy=%0h rdv=%0h want 0/0/0/0", i, bus.MemWE, bus.DoneV, bus.BusyV, bus.RDataV); end
            @(negedge clk);
        end
        bus.ReqS = 1'b1; bus.AddrS = 24'h10; bus.ReqV = 1'b1; bus.AddrV = 24'h50;
        #1;
        n_checks++; if (bus.GntS !== 1'b1) begin n_fail++; $display("FAIL midrst_prio: got gnt=%0h want 1", bus.GntS); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_random();
        int m_pos = 0;
        logic m_prio = 1'b0, m_done = 1'b0, m_we = 1'b0;
        logic [N-1:0] m_base = '0;
        logic [LANES*N-1:0] m_wdata = '0, m_rdatav = '0;
        logic v_pend = 1'b0;
        int v_age = 0;
        logic e_gs, e_gv, e_we, new_done;
        logic [N-1:0] e_addr, e_wd, e_rds;
        logic [2*N-1:0] got;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            bus.ReqS   = 1'($urandom_range(0, 1));
            bus.WeS    = 1'($urandom_range(0, 1));
            bus.AddrS  = N'($urandom);
            bus.WDataS = N'($urandom);
            if (!v_pend && $urandom_range(0, 3) == 0) begin
                v_pend = 1'b1; v_age = 0;
                bus.WeV = 1'($urandom_range(0, 1));
                bus.AddrV = N'($urandom);
                for (int k = 0; k < LANES; k++) bus.WDataV[k*N +: N] = N'($urandom);
            end
            bus.ReqV = v_pend;
            #1;
            e_gs = (m_pos == 0) && bus.ReqS && !(bus.ReqV && m_prio && !m_done);
            e_gv = (m_pos == 0) && bus.ReqV && !m_done && (!bus.ReqS || m_prio);
            e_we = 1'b0; e_addr = '0; e_wd = '0; e_rds = '0;
            if (e_gs) begin
                e_we = bus.WeS; e_addr = bus.AddrS; e_wd = bus.WDataS; e_rds = mem[bus.AddrS[7:0]];
            end else if (m_pos != 0) begin
                e_we = m_we; e_addr = m_base + N'(m_pos - 1); e_wd = m_wdata[(m_pos-1)*N +: N];
            end
            if (e_we) exp_q.push_back({e_addr, e_wd});
            n_checks++; if (bus.GntS !== e_gs || bus.StallS !== (bus.ReqS && !e_gs)) begin n_fail++; $display("FAIL rnd%0d_gnt: got gnt=%0h stall=%0h want %0h/%0h", cyc, bus.GntS, bus.StallS, e_gs, bus.ReqS && !e_gs); end
            n_checks++; if (bus.BusyV !== (m_pos != 0) || bus.DoneV !== m_done) begin n_fail++; $display("FAIL rnd%0d_flags: got busy=%0h done=%0h want %0h/%0h", cyc, bus.BusyV, bus.DoneV, m_pos != 0, m_done); end
            n_checks++; if (bus.MemAddr !== e_addr || bus.MemWE !== e_we || bus.RDataS !== e_rds) begin n_fail++; $display("FAIL rnd%0d_mem: got a=%0h we=%0h rds=%0h want %0h/%0h/%0h", cyc, bus.MemAddr, bus.MemWE, bus.RDataS, e_addr, e_we, e_rds); end
            n_checks++; if (bus.RDataV !== m_rdatav) begin n_fail++; $display("FAIL rnd%0d_rdatav: got %0h want %0h", cyc, bus.RDataV, m_rdatav); end
            if (bus.MemWE === 1'b1) begin
                got = {bus.MemAddr, bus.MemWData};
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL rnd%0d_write: got %0h want no write", cyc, got); end
                else if (exp_q[0] !== got) begin n_fail++; $display("FAIL rnd%0d_write: got %0h want %0h", cyc, got, exp_q[0]); void'(exp_q.pop_front()); end
                else void'(exp_q.pop_front());
            end
            if (exp_q.size() != 0) begin
                n_checks++; n_fail++; $display("FAIL rnd%0d_write: got none want %0h", cyc, exp_q[0]);
                exp_q.delete();
            end
            // reference model advances across the coming edge
            if (m_pos != 0 && !m_we) m_rdatav[(m_pos-1)*N +: N] = mem[e_addr[7:0]];
            new_done = (m_pos == LANES);
            if (e_gs && bus.ReqV && !m_done) m_prio = 1'b1;
            if (e_gv) begin
                m_pos = 1; m_base = bus.AddrV; m_we = bus.WeV; m_wdata = bus.WDataV; m_prio = 1'b0;
            end else if (m_pos == LANES) begin
                m_pos = 0;
            end else if (m_pos != 0) begin
                m_pos++;
            end
            m_done = new_done;
            // requester side: release after completion, bounded wait
            if (v_pend) begin
                v_age++;
                if (bus.DoneV === 1'b1) v_pend = 1'b0;
                else if (v_age > LANES + 12) begin
                    n_checks++; n_fail++; $display("FAIL rnd%0d_timeout: got no DoneV want DoneV", cyc);
                    v_pend = 1'b0;
                end
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        for (int i = 0; i < 256; i++) mem[i] = N'($urandom);
        mem[8'h10] = 24'hABCDEF;
        repeat (2) @(negedge clk);
        test_reset();
        test_scalar();
        test_vec_write();
        test_contention();
        test_wrap();
        test_reset_mid_vec();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
